pmod_serial_display: RTL and testbench

Parametrised serial-to-decimal display receiver. Samples a UART-style serial line from a PMOD pin, assembles a DATA_W-bit word, converts it to DIGITS decimal digits with a sequential double-dabble converter, and drives DIGITS seven-segment displays. Replaces the fixed 9-bit, 2-digit receiver, which sampled every other clock without framing. Sits between the board PMOD header and the seven-segment outputs.

---
 rtl/pmod_serial_display_pkg.sv | 47 ++++
 rtl/pmod_serial_display_if.sv | 27 ++
 rtl/pmod_serial_display_bin2bcd_seq.sv | 87 ++++++++
 rtl/pmod_serial_display.sv | 196 +++++++++++++++++++
 tb/tb_pmod_serial_display.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmod_serial_display_pkg.sv
// pmod_ser_pkg: shared constants for the PMOD serial display receiver.
//   - receiver and converter FSM state encodings
//   - active-low gfedcba segment codes for digits, dash and blank
//   - seg_of(): BCD nibble to segment code (non-decimal nibbles blank)
// No ports; imported by pmod_serial_display and bin2bcd_seq.
package pmod_ser_pkg;

  // Receiver FSM encoding
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t IDLE   = 3'd0;
  localparam rx_state_t START  = 3'd1;
  localparam rx_state_t DATA   = 3'd2;
  localparam rx_state_t PARITY = 3'd3;
  localparam rx_state_t STOP   = 3'd4;

  // Converter FSM encoding
  typedef logic [1:0] cv_state_t;
  localparam cv_state_t CIDLE = 2'd0;
  localparam cv_state_t SHIFT = 2'd1;
  localparam cv_state_t DONE  = 2'd2;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pmod_serial_display_if.sv
// pmod_serial_display_if: serial input plus display/status outputs.
//   i_Serial    serial line into the receiver
//   o_Segments  7*DIGITS active-low segment codes, units in [6:0]
//   o_Value     last accepted word
//   o_Valid / o_FrameErr / o_ParityErr  one-cycle status pulses
// Modports: slave = receiver side, master = line driver / observer.
interface pmod_serial_display_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 2
);
  logic                  i_Serial;
  logic [7*DIGITS-1:0]   o_Segments;
  logic [DATA_W-1:0]     o_Value;
  logic                  o_Valid;
  logic                  o_FrameErr;
  logic                  o_ParityErr;

  modport slave (
    input  i_Serial,
    output o_Segments, o_Value, o_Valid, o_FrameErr, o_ParityErr
  );

  modport master (
    output i_Serial,
    input  o_Segments, o_Value, o_Valid, o_FrameErr, o_ParityErr
  );
endinterface

// File: rtl/pmod_serial_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one add-3/shift iteration per cycle.
//   i_Clk, i_Rst  clock, synchronous active-high reset
//   start         load bin and begin (accepted in CIDLE or DONE)
//   bin           binary word, DATA_W bits
//   busy          high while iterating
//   done          high in the final iteration cycle; bcd holds the result then
//   bcd           4*DIGITS-bit result of the iteration in progress
module bin2bcd_seq
  import pmod_ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(DATA_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

  cv_state_t          state_r;
  logic [DATA_W-1:0]  bin_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [ITER_W-1:0]  iter_r;
  logic [BCD_W-1:0]   corr_s;
  logic [BCD_W-1:0]   bcd_next_s;
  logic [3:0]         nib_s;

  // Add-3 correction on every nibble, then shift in the next binary MSB
  always_comb begin
    corr_s = bcd_r;
    nib_s  = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      nib_s = bcd_r[4*d +: 4];
      if (nib_s >= 4'd5) begin
        corr_s[4*d +: 4] = nib_s + 4'd3;
      end else begin
        corr_s[4*d +: 4] = nib_s;
      end
    end
    bcd_next_s = {corr_s[BCD_W-2:0], bin_r[DATA_W-1]};
  end

  // The result is taken from the last iteration's next value so the
  // caller can register it at the same edge that completes the conversion
  assign busy = (state_r == SHIFT);
  assign done = (state_r == SHIFT) && (iter_r == ITER_LAST);
  assign bcd  = bcd_next_s;

  // Converter state, working registers and iteration counter
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r <= CIDLE;
      bin_r   <= '0;
      bcd_r   <= '0;
      iter_r  <= '0;
    end else begin
      case (state_r)
        CIDLE, DONE: begin
          if (start) begin
            bin_r   <= bin;
            bcd_r   <= '0;
            iter_r  <= '0;
            state_r <= SHIFT;
          end else begin
            state_r <= CIDLE;
          end
        end
        SHIFT: begin
          bcd_r <= bcd_next_s;
          bin_r <= {bin_r[DATA_W-2:0], 1'b0};
          if (iter_r == ITER_LAST) begin
            state_r <= DONE;
          end else begin
            iter_r <= iter_r + 1'b1;
          end
        end
        default: state_r <= CIDLE;
      endcase
    end
  end
endmodule

// File: rtl/pmod_serial_display.sv
// pmod_serial_display: UART-style serial receiver driving DIGITS decimal
// seven-segment displays through a sequential binary-to-BCD converter.
//   i_Clk  system clock
//   i_Rst  synchronous active-high reset
//   bus    pmod_serial_display_if.slave (i_Serial in; o_Segments, o_Value,
//          o_Valid, o_FrameErr, o_ParityErr out)
// Build option: define PMOD_SER_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit.
module pmod_serial_display
  import pmod_ser_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DIGITS       = 2,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  pmod_serial_display_if.slave   bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [31:0]      OVF_LIMIT = 32'(10**DIGITS);

  logic                  sync_meta_r;
  logic                  rx_r;
  rx_state_t             rx_state_r;
  logic [CNT_W-1:0]      clk_cnt_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [DATA_W-1:0]     shift_r;
  logic [DATA_W-1:0]     value_r;
  logic                  ovf_r;
  logic                  frame_err_r;
  logic [7*DIGITS-1:0]   seg_r;
  logic                  valid_r;
  logic                  stop_tick_s;
  logic                  accept_s;
  logic                  conv_start_s;
  logic                  conv_busy_s;
  logic                  conv_done_s;
  logic [4*DIGITS-1:0]   conv_bcd_s;
`ifdef PMOD_SER_PARITY_EN
  logic                  parity_bad_r;
  logic                  parity_err_r;
`endif

  // Two-flop synchroniser; line idles high
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync_meta_r <= 1'b1;
      rx_r        <= 1'b1;
    end else begin
      sync_meta_r <= bus.i_Serial;
      rx_r        <= sync_meta_r;
    end
  end

  // Stop-bit sample point and frame acceptance
  always_comb begin
    stop_tick_s = (rx_state_r == STOP) && (clk_cnt_r == BIT_LAST);
`ifdef PMOD_SER_PARITY_EN
    accept_s    = stop_tick_s && rx_r && !parity_bad_r;
`else
    accept_s    = stop_tick_s && rx_r;
`endif
    conv_start_s = accept_s && !conv_busy_s;
  end

  // Receiver FSM: mid-bit sampling, LSB-first shift, stop/parity checks
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_state_r   <= IDLE;
      clk_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      value_r      <= '0;
      ovf_r        <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef PMOD_SER_PARITY_EN
      parity_bad_r <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r  <= 1'b0;
`ifdef PMOD_SER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (rx_state_r)
        IDLE: begin
          clk_cnt_r <= '0;
          if (!rx_r) rx_state_r <= START;
        end
        START: begin
          // Re-check half a bit later so a short low pulse is ignored
          if (clk_cnt_r == HALF_LAST) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= '0;
`ifdef PMOD_SER_PARITY_EN
            parity_bad_r <= 1'b0;
`endif
            rx_state_r <= rx_r ? IDLE : DATA;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r <= '0;
            shift_r   <= {rx_r, shift_r[DATA_W-1:1]};
            if (bit_cnt_r == DATA_LAST) begin
`ifdef PMOD_SER_PARITY_EN
              rx_state_r <= PARITY;
`else
              rx_state_r <= STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
`ifdef PMOD_SER_PARITY_EN
        PARITY: begin
          if (clk_cnt_r == BIT_LAST) begin
            clk_cnt_r    <= '0;
            parity_bad_r <= rx_r ^ (^shift_r);
            rx_state_r   <= STOP;
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
`endif
        STOP: begin
          if (stop_tick_s) begin
            clk_cnt_r  <= '0;
            rx_state_r <= IDLE;
            if (!rx_r) begin
              frame_err_r <= 1'b1;
`ifdef PMOD_SER_PARITY_EN
            end else if (parity_bad_r) begin
              parity_err_r <= 1'b1;
`endif
            end else begin
              value_r <= shift_r;
              ovf_r   <= ({{(32-DATA_W){1'b0}}, shift_r} >= OVF_LIMIT);
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
          end
        end
        default: rx_state_r <= IDLE;
      endcase
    end
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .start (conv_start_s),
    .bin   (shift_r),
    .busy  (conv_busy_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // Segment registers and valid pulse, loaded from the final BCD iteration
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      seg_r   <= {DIGITS{SEG_DIGIT[0]}};
      valid_r <= 1'b0;
    end else begin
      valid_r <= conv_done_s;
      if (conv_done_s) begin
        for (int d = 0; d < DIGITS; d++) begin
          seg_r[7*d +: 7] <= ovf_r ? SEG_DASH : seg_of(conv_bcd_s[4*d +: 4]);
        end
      end
    end
  end

  assign bus.o_Segments = seg_r;
  assign bus.o_Value    = value_r;
  assign bus.o_Valid    = valid_r;
  assign bus.o_FrameErr = frame_err_r;
`ifdef PMOD_SER_PARITY_EN
  assign bus.o_ParityErr = parity_err_r;
`else
  assign bus.o_ParityErr = 1'b0;
`endif
endmodule

// File: tb/tb_pmod_serial_display.sv
// Self-checking bench for pmod_serial_display at default parameters.
// Build option PMOD_SER_PARITY_EN adds parity bits and parity tests.
module tb_pmod_serial_display;
  localparam int CPB = 4;

  typedef struct {
    logic [7:0]  val;
    logic [13:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Monitor records
  int          valid_cnt = 0;
  int          ferr_cnt = 0;
  int          perr_cnt = 0;
  int          last_valid_cyc = 0;
  int          last_val_cyc = 0;
  int          last_ferr_cyc = 0;
  logic [13:0] cap_seg = 14'd0;
  logic [7:0]  cap_val = 8'd0;
  logic [7:0]  prev_val = 8'd0;

  // Expected display state from the model
  logic [13:0] exp_disp_seg;
  logic [7:0]  exp_disp_val;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  pmod_serial_display_if #(.DATA_W(8), .DIGITS(2)) bus();

  pmod_serial_display #(
    .DATA_W(8), .DIGITS(2), .CLKS_PER_BIT(CPB)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_Valid === 1'b1) begin
      valid_cnt      = valid_cnt + 1;
      last_valid_cyc = cyc;
      cap_seg        = bus.o_Segments;
      cap_val        = bus.o_Value;
    end
    if (bus.o_Value !== prev_val) begin
      last_val_cyc = cyc;
      prev_val     = bus.o_Value;
    end
    if (bus.o_FrameErr === 1'b1) begin
      ferr_cnt      = ferr_cnt + 1;
      last_ferr_cyc = cyc;
    end
    if (bus.o_ParityErr === 1'b1) perr_cnt = perr_cnt + 1;
  end

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] exp_seg(input int v);
    if (v >= 100) return {7'b0111111, 7'b0111111};
    return {digit_seg(v / 10), digit_seg(v % 10)};
  endfunction

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.i_Serial = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    exp_t e;
    if (stop_bit && !par_flip) begin
      e.val = data;
      e.seg = exp_seg(int'(data));
      sb_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
`ifdef PMOD_SER_PARITY_EN
    drive_bit((^data) ^ par_flip);
`endif
    drive_bit(stop_bit);
    @(negedge clk);
    bus.i_Serial = 1'b1;
  endtask

  task automatic wait_valid(input int target, output bit ok);
    int n;
    n = 0;
    while (valid_cnt < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (valid_cnt >= target);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.o_Segments !== 14'b1000000_1000000) begin
      failures++; $display("FAIL reset_segments got=%b want=%b", bus.o_Segments, 14'b1000000_1000000);
    end
    checks++;
    if (bus.o_Value !== 8'd0) begin
      failures++; $display("FAIL reset_value got=%h want=00", bus.o_Value);
    end
    checks++;
    if (bus.o_Valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b want=0", bus.o_Valid);
    end
    checks++;
    if (bus.o_FrameErr !== 1'b0) begin
      failures++; $display("FAIL reset_frameerr got=%b want=0", bus.o_FrameErr);
    end
    checks++;
    if (bus.o_ParityErr !== 1'b0) begin
      failures++; $display("FAIL reset_parityerr got=%b want=0", bus.o_ParityErr);
    end
  endtask

  // Accept one good frame, compare against the scoreboard and check timing
  task automatic test_value(input logic [7:0] v, input string name);
    int   base;
    bit   ok;
    exp_t e;
    base = valid_cnt;
    send_frame(v, 1'b1, 1'b0);
    wait_valid(base + 1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL %s_timeout got=%0d valids want=%0d", name, valid_cnt - base, 1);
    end
    checks++;
    if (sb_q.size() == 0) begin
      failures++; $display("FAIL %s_scoreboard got=empty want=1 entry", name);
    end else begin
      e = sb_q.pop_front();
      if (cap_val !== e.val) begin
        failures++; $display("FAIL %s_value got=%h want=%h", name, cap_val, e.val);
      end
      checks++;
      if (cap_seg !== e.seg) begin
        failures++; $display("FAIL %s_segments got=%b want=%b", name, cap_seg, e.seg);
      end
      exp_disp_seg = e.seg;
      exp_disp_val = e.val;
    end
    checks++;
    if (last_valid_cyc - last_val_cyc !== 8) begin
      failures++; $display("FAIL %s_latency got=%0d want=8", name, last_valid_cyc - last_val_cyc);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - base !== 1) begin
      failures++; $display("FAIL %s_valid_count got=%0d want=1", name, valid_cnt - base);
    end
  endtask

  task automatic test_42;
    test_value(8'd42, "v42");
    checks++;
    if (cap_seg[6:0] !== 7'b0100100 || cap_seg[13:7] !== 7'b0011001) begin
      failures++; $display("FAIL v42_digits got=%b want=%b", cap_seg, 14'b0011001_0100100);
    end
    checks++;
    if (cap_val !== 8'h2A) begin
      failures++; $display("FAIL v42_hex got=%h want=2a", cap_val);
    end
  endtask

  task automatic test_overflow;
    test_value(8'd150, "v150");
    checks++;
    if (cap_seg !== 14'b0111111_0111111 || cap_val !== 8'h96) begin
      failures++; $display("FAIL v150_dash got=%b/%h want=%b/96", cap_seg, cap_val, 14'b0111111_0111111);
    end
  endtask

  task automatic test_frame_err;
    int vb, fb, ret_cyc;
    vb = valid_cnt;
    fb = ferr_cnt;
    send_frame(8'd7, 1'b0, 1'b0);
    ret_cyc = cyc;
    repeat (20) @(negedge clk);
    checks++;
    if (ferr_cnt - fb !== 1) begin
      failures++; $display("FAIL ferr_count got=%0d want=1", ferr_cnt - fb);
    end
    checks++;
    if (last_ferr_cyc - ret_cyc < 0 || last_ferr_cyc - ret_cyc > 3) begin
      failures++; $display("FAIL ferr_timing got=%0d want=0..3", last_ferr_cyc - ret_cyc);
    end
    checks++;
    if (valid_cnt - vb !== 0) begin
      failures++; $display("FAIL ferr_no_valid got=%0d want=0", valid_cnt - vb);
    end
    checks++;
    if (bus.o_Segments !== exp_disp_seg || bus.o_Value !== exp_disp_val) begin
      failures++; $display("FAIL ferr_display_kept got=%b/%h want=%b/%h",
                           bus.o_Segments, bus.o_Value, exp_disp_seg, exp_disp_val);
    end
  endtask

  task automatic test_glitch;
    int vb, fb, pb;
    vb = valid_cnt; fb = ferr_cnt; pb = perr_cnt;
    @(negedge clk);
    bus.i_Serial = 1'b0;
    @(negedge clk);
    bus.i_Serial = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - vb !== 0) begin
      failures++; $display("FAIL glitch_valid got=%0d want=0", valid_cnt - vb);
    end
    checks++;
    if (ferr_cnt - fb !== 0 || perr_cnt - pb !== 0) begin
      failures++; $display("FAIL glitch_errors got=%0d/%0d want=0/0", ferr_cnt - fb, perr_cnt - pb);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int vb;
    d  = 8'd99;
    vb = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    @(negedge clk);
    bus.i_Serial = d[3];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.i_Serial = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_Segments !== 14'b1000000_1000000 || bus.o_Value !== 8'd0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%h want=%b/00",
                           bus.o_Segments, bus.o_Value, 14'b1000000_1000000);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (valid_cnt - vb !== 0) begin
      failures++; $display("FAIL midrst_no_valid got=%0d want=0", valid_cnt - vb);
    end
    test_value(8'd5, "after_rst5");
    checks++;
    if (cap_seg !== 14'b1000000_0010010) begin
      failures++; $display("FAIL after_rst5_digits got=%b want=%b", cap_seg, 14'b1000000_0010010);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [7];
    int base;
    vals = '{8'd0, 8'd99, 8'd100, 8'd255, 8'd9, 8'd10, 8'd0};
    vals[6] = 8'($urandom_range(0, 255));
    base = valid_cnt;
    fork
      begin
        for (int k = 0; k < 7; k++) send_frame(vals[k], 1'b1, 1'b0);
      end
      begin
        for (int k = 0; k < 7; k++) begin
          bit   ok;
          exp_t e;
          wait_valid(base + k + 1, ok);
          checks++;
          if (!ok) begin
            failures++; $display("FAIL b2b_timeout frame=%0d got=%0d want=%0d", k, valid_cnt - base, k + 1);
          end
          checks++;
          if (sb_q.size() == 0) begin
            failures++; $display("FAIL b2b_scoreboard frame=%0d got=empty want=entry", k);
          end else begin
            e = sb_q.pop_front();
            if (cap_val !== e.val || cap_seg !== e.seg) begin
              failures++; $display("FAIL b2b_frame%0d got=%h/%b want=%h/%b", k, cap_val, cap_seg, e.val, e.seg);
            end
            exp_disp_seg = e.seg;
            exp_disp_val = e.val;
          end
        end
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt - base !== 7) begin
      failures++; $display("FAIL b2b_valid_count got=%0d want=7", valid_cnt - base);
    end
  endtask

`ifdef PMOD_SER_PARITY_EN
  task automatic test_parity;
    int vb, pb;
    vb = valid_cnt;
    pb = perr_cnt;
    send_frame(8'd3, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (perr_cnt - pb !== 1) begin
      failures++; $display("FAIL parity_err_count got=%0d want=1", perr_cnt - pb);
    end
    checks++;
    if (valid_cnt - vb !== 0 || bus.o_Segments !== exp_disp_seg) begin
      failures++; $display("FAIL parity_display_kept got=%0d/%b want=0/%b",
                           valid_cnt - vb, bus.o_Segments, exp_disp_seg);
    end
    test_value(8'd3, "parity_ok3");
    checks++;
    if (cap_seg[6:0] !== 7'b0110000) begin
      failures++; $display("FAIL parity_ok3_units got=%b want=0110000", cap_seg[6:0]);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.i_Serial = 1'b1;
    exp_disp_seg = 14'b1000000_1000000;
    exp_disp_val = 8'd0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_42;
    test_overflow;
    test_frame_err;
    test_glitch;
    test_reset_mid_frame;
    test_back_to_back;
`ifdef PMOD_SER_PARITY_EN
    test_parity;
`endif
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drained got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
